// File: rtl/pipe_sched.sv
// Stall/flush scheduler for the 5-stage pipeline: merges hazard, redirect, mult/div and memory-wait
// requests into per-stage write-enable/flush controls, sequences mult/div latency, counts stalls.
module pipe_sched #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             ID_redirect,
  input  logic             EX_redirect,
  input  logic             EX_mdStart,
  input  logic             EX_mdIsDiv,
  input  logic             mem_wait,
  output logic             PC_we,
  output logic             IFID_we,
  output logic             IFID_flush,
  output logic             IDEX_we,
  output logic             IDEX_flush,
  output logic             EXMEM_we,
  output logic             EXMEM_flush,
  output logic             MEMWB_we,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned MD_W    = $clog2(MAX_LAT) + 1;

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t          state, state_nxt;
  logic [MD_W-1:0] md_cnt, md_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    PC_we       = 1'b1;
    IFID_we     = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_we     = 1'b1;
    IDEX_flush  = 1'b0;
    EXMEM_we    = 1'b1;
    EXMEM_flush = 1'b0;
    MEMWB_we    = 1'b1;
    md_done     = 1'b0;
    md_busy     = (state == MD_BUSY);

    if (!rst_n) begin
      // reset: defaults already give all enables high, no flush, no done pulse
    end else if (mem_wait) begin
      PC_we    = 1'b0;
      IFID_we  = 1'b0;
      IDEX_we  = 1'b0;
      EXMEM_we = 1'b0;
      MEMWB_we = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (EX_mdStart) begin
            state_nxt  = MD_BUSY;
            md_cnt_nxt = EX_mdIsDiv ? MD_W'(DIV_LAT - 1) : MD_W'(MUL_LAT - 1);
          end
        end
        MD_BUSY: begin
          md_cnt_nxt = md_cnt - 1'b1;
          if (md_cnt == MD_W'(1)) begin
            md_done    = 1'b1;
            state_nxt  = RUN;
            md_cnt_nxt = '0;
          end
        end
        default: state_nxt = RUN;
      endcase

      // A branch cannot occupy EX during a mult/div, so EX_redirect only counts in RUN.
      if (state == RUN && EX_redirect) begin
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if ((state == MD_BUSY && !md_done) || (state == RUN && EX_mdStart)) begin
        PC_we       = 1'b0;
        IFID_we     = 1'b0;
        IDEX_we     = 1'b0;
        EXMEM_flush = 1'b1;
      end else if (md_done) begin
        // EX result advances; all stages enabled
      end else if (hz_stall) begin
        PC_we      = 1'b0;
        IFID_we    = 1'b0;
        IDEX_flush = 1'b1;
      end else if (ID_redirect) begin
        IFID_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!PC_we && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_sched.sv
// Scoreboard bench for pipe_sched: directed per-cycle vectors with hand-written expected controls,
// checked on the falling edge against a 16-bit and a 4-bit stall-counter instance.
module tb_pipe_sched;

  localparam logic [7:0] C_RUN = 8'b1101_0101;
  localparam logic [7:0] C_FRZ = 8'b0000_0000;
  localparam logic [7:0] C_EXR = 8'b1111_1101;
  localparam logic [7:0] C_MDS = 8'b0000_0111;
  localparam logic [7:0] C_HZ  = 8'b0001_1101;
  localparam logic [7:0] C_IDR = 8'b1111_0101;

  logic clk = 1'b0;
  logic rst_n, hz_stall, ID_redirect, EX_redirect, EX_mdStart, EX_mdIsDiv, mem_wait;

  logic        pc_a, ifidwe_a, ifidfl_a, idexwe_a, idexfl_a, exmemwe_a, exmemfl_a, memwbwe_a;
  logic        busy_a, done_a;
  logic [15:0] scnt_a;
  logic        pc_b, ifidwe_b, ifidfl_b, idexwe_b, idexfl_b, exmemwe_b, exmemfl_b, memwbwe_b;
  logic        busy_b, done_b;
  logic [3:0]  scnt_b;

  always #5 clk = ~clk;

  pipe_sched #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .ID_redirect(ID_redirect),
    .EX_redirect(EX_redirect), .EX_mdStart(EX_mdStart), .EX_mdIsDiv(EX_mdIsDiv),
    .mem_wait(mem_wait), .PC_we(pc_a), .IFID_we(ifidwe_a), .IFID_flush(ifidfl_a),
    .IDEX_we(idexwe_a), .IDEX_flush(idexfl_a), .EXMEM_we(exmemwe_a), .EXMEM_flush(exmemfl_a),
    .MEMWB_we(memwbwe_a), .md_busy(busy_a), .md_done(done_a), .stall_cnt(scnt_a)
  );

  pipe_sched #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .ID_redirect(ID_redirect),
    .EX_redirect(EX_redirect), .EX_mdStart(EX_mdStart), .EX_mdIsDiv(EX_mdIsDiv),
    .mem_wait(mem_wait), .PC_we(pc_b), .IFID_we(ifidwe_b), .IFID_flush(ifidfl_b),
    .IDEX_we(idexwe_b), .IDEX_flush(idexfl_b), .EXMEM_we(exmemwe_b), .EXMEM_flush(exmemfl_b),
    .MEMWB_we(memwbwe_b), .md_busy(busy_b), .md_done(done_b), .stall_cnt(scnt_b)
  );

  typedef struct {
    logic [7:0]  ctrl;
    logic        busy;
    logic        busy_care;
    logic        done;
    int unsigned scnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_scnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input string tag, input int unsigned act,
                       input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  // Monitor: every driven cycle presents an output set; pop its expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctrl16", e.tag, {24'd0, pc_a, ifidwe_a, ifidfl_a, idexwe_a, idexfl_a,
                                exmemwe_a, exmemfl_a, memwbwe_a}, {24'd0, e.ctrl});
        check("ctrl4", e.tag, {24'd0, pc_b, ifidwe_b, ifidfl_b, idexwe_b, idexfl_b,
                               exmemwe_b, exmemfl_b, memwbwe_b}, {24'd0, e.ctrl});
        check("md_done16", e.tag, {31'd0, done_a}, {31'd0, e.done});
        check("md_done4", e.tag, {31'd0, done_b}, {31'd0, e.done});
        if (e.busy_care) begin
          check("md_busy16", e.tag, {31'd0, busy_a}, {31'd0, e.busy});
          check("md_busy4", e.tag, {31'd0, busy_b}, {31'd0, e.busy});
        end
        check("stall_cnt16", e.tag, {16'd0, scnt_a}, e.scnt);
        check("stall_cnt4", e.tag, {28'd0, scnt_b}, (e.scnt > 15) ? 15 : e.scnt);
      end
    end
  end

  // One clock of stimulus: {rst_n, hz, id_redir, ex_redir, md_start, is_div, mem_wait}
  task automatic step(input string tag, input logic [6:0] in, input logic [7:0] ctrl,
                      input logic busy, input logic done);
    exp_t e;
    @(posedge clk);
    #1;
    {rst_n, hz_stall, ID_redirect, EX_redirect, EX_mdStart, EX_mdIsDiv, mem_wait} = in;
    e.ctrl      = ctrl;
    e.busy      = busy;
    e.busy_care = in[6];
    e.done      = done;
    e.scnt      = exp_scnt;
    e.tag       = tag;
    sb.push_back(e);
    if (!in[6])        exp_scnt = 0;
    else if (!ctrl[7]) exp_scnt++;
  endtask

  localparam logic [6:0] I_RST  = 7'b0_000000;
  localparam logic [6:0] I_IDLE = 7'b1_000000;
  localparam logic [6:0] I_MUL  = 7'b1_000100;
  localparam logic [6:0] I_DIV  = 7'b1_000110;
  localparam logic [6:0] I_MDH  = 7'b1_000100;

  initial begin
    {rst_n, hz_stall, ID_redirect, EX_redirect, EX_mdStart, EX_mdIsDiv, mem_wait} = I_RST;
    @(posedge clk);

    step("reset", I_RST, C_RUN, 1'b0, 1'b0);
    step("reset", I_RST, C_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("idle", I_IDLE, C_RUN, 1'b0, 1'b0);

    // multiply: 3 stall cycles, done on cycle 4 while start is still high, no restart
    step("mul_c1", I_MUL, C_MDS, 1'b0, 1'b0);
    step("mul_c2_exr", 7'b1_001100, C_MDS, 1'b1, 1'b0);
    step("mul_c3", I_MUL, C_MDS, 1'b1, 1'b0);
    step("mul_done", I_MUL, C_RUN, 1'b1, 1'b1);
    step("mul_after", I_IDLE, C_RUN, 1'b0, 1'b0);

    step("hz_idr", 7'b1_110000, C_HZ, 1'b0, 1'b0);
    step("idr_only", 7'b1_010000, C_IDR, 1'b0, 1'b0);
    step("exr_hz", 7'b1_101000, C_EXR, 1'b0, 1'b0);
    step("idle2", I_IDLE, C_RUN, 1'b0, 1'b0);

    // divide: start blocked by mem_wait, then 37 cycles including a 5-cycle freeze
    step("div_wait_start", 7'b1_000111, C_FRZ, 1'b0, 1'b0);
    step("div_c1", I_DIV, C_MDS, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("div_busy_a", I_MDH, C_MDS, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)  step("div_freeze", 7'b1_100101, C_FRZ, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step("div_busy_b", I_MDH, C_MDS, 1'b1, 1'b0);
    step("div_done", I_MDH, C_RUN, 1'b1, 1'b1);
    step("div_after", I_IDLE, C_RUN, 1'b0, 1'b0);

    // saturation from a cleared counter, then a divide aborted by reset at cycle 10
    step("sat_reset", I_RST, C_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat_hz", 7'b1_100000, C_HZ, 1'b0, 1'b0);
    step("abort_c1", I_DIV, C_MDS, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("abort_busy", I_MDH, C_MDS, 1'b1, 1'b0);
    step("abort_rst", 7'b0_000110, C_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("abort_after", I_IDLE, C_RUN, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
